// File: rtl/pkt_buf_pkg.sv
// Shared types for the scheduler packet buffer: writer FSM states, descriptor layout
// and the default buffer address width.
package pkt_buf_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 12;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StDrop,
        StDesc
    } wr_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH_DEF-1:0] addr;
        logic [ADDR_WIDTH_DEF-1:0] len;
    } pkt_desc_t;

endpackage

// File: rtl/pkt_buffer_writer.sv
// Buffer ingress: stores AXI-Stream beats at the free-list head, emits a descriptor per packet
// and drops whole packets that start while the address manager is almost full.
module pkt_buffer_writer
    import pkt_buf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    input  logic [ADDR_WIDTH-1:0] am_fl_head,
    input  logic                  am_almost_full,
    output logic                  am_wr_en,
    output logic                  buf_wr_en,
    output logic [ADDR_WIDTH-1:0] buf_wr_addr,
    output logic [DATA_WIDTH-1:0] buf_wr_data,
    output logic                  m_desc_valid,
    input  logic                  m_desc_ready,
    output logic [ADDR_WIDTH-1:0] m_desc_addr,
    output logic [ADDR_WIDTH-1:0] m_desc_len,
    output logic [CNT_WIDTH-1:0]  drop_count
);

    wr_state_e             state_q;
    logic [ADDR_WIDTH-1:0] sop_addr_q;
    logic [ADDR_WIDTH-1:0] len_q;
    logic                  desc_valid_q;
    logic [CNT_WIDTH-1:0]  drop_cnt_q;

    logic accept;
    logic store;

    // Gated by rstn so nothing is accepted (and nothing written) while in reset.
    assign s_axis_tready = rstn & (state_q != StDesc);
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign store         = accept & (((state_q == StIdle) & ~am_almost_full) |
                                     (state_q == StWrite));

    assign buf_wr_en    = store;
    assign am_wr_en     = store;
    assign buf_wr_addr  = am_fl_head;
    assign buf_wr_data  = s_axis_tdata;

    assign m_desc_valid = desc_valid_q;
    assign m_desc_addr  = sop_addr_q;
    assign m_desc_len   = len_q;
    assign drop_count   = drop_cnt_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= StIdle;
            sop_addr_q   <= '0;
            len_q        <= '0;
            desc_valid_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (am_almost_full) begin
                            if (drop_cnt_q != '1) begin
                                drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
                            end
                            state_q <= s_axis_tlast ? StIdle : StDrop;
                        end else begin
                            sop_addr_q <= am_fl_head;
                            len_q      <= ADDR_WIDTH'(1);
                            if (s_axis_tlast) begin
                                state_q      <= StDesc;
                                desc_valid_q <= 1'b1;
                            end else begin
                                state_q <= StWrite;
                            end
                        end
                    end
                end
                StWrite: begin
                    // Almost-full is deliberately ignored once a packet has started.
                    if (accept) begin
                        len_q <= len_q + ADDR_WIDTH'(1);
                        if (s_axis_tlast) begin
                            state_q      <= StDesc;
                            desc_valid_q <= 1'b1;
                        end
                    end
                end
                StDrop: begin
                    if (accept && s_axis_tlast) begin
                        state_q <= StIdle;
                    end
                end
                StDesc: begin
                    if (m_desc_ready) begin
                        desc_valid_q <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
